// File: rtl/rom_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// rom_pkg : shared ROM geometry and burst-reader state encoding
// Rev 1.0
// ---------------------------------------------------------------
package rom_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_stream_reg.sv
`default_nettype none
// ---------------------------------------------------------------
// rom_stream_reg : one-entry valid/ready holding register {last, data}
// Rev 1.0
// ---------------------------------------------------------------
module rom_stream_reg
  import rom_pkg::*;
#(
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] din_data,
  input  logic              din_last,
  output logic              can_load,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W:0] hold;

  // A new word may enter when the slot is empty or is being emptied this cycle.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold      <= '0;
      out_valid <= 1'b0;
    end else if (capture && can_load) begin
      hold      <= {din_last, din_data};
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      hold[DATA_W] <= 1'b0;
      out_valid    <= 1'b0;
    end
  end

  assign out_data = hold[DATA_W-1:0];
  assign out_last = hold[DATA_W];

endmodule
`default_nettype wire

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ---------------------------------------------------------------
// rom_burst_reader : turns a start/length request into a wrapped ROM read burst
// Rev 1.0
// ---------------------------------------------------------------
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_read_enable,
  output logic              rom_chip_enable,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready
);

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     rem;
  logic                reading;
  logic                can_load;
  logic                rem_is_one;

  assign reading     = (state == READ);
  assign rem_is_one  = (rem == (ADDR_W+1)'(1));
  assign rom_address = addr;

  rom_stream_reg #(
    .DATA_W(DATA_W)
  ) u_stream_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .capture  (reading),
    .din_data (rom_data),
    .din_last (rem_is_one),
    .can_load (can_load),
    .out_data (out_data),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      rem   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start && burst_len != '0) begin
        addr <= start_addr;
        rem  <= burst_len;
      end else if (reading && can_load) begin
        // Natural ADDR_W-bit overflow gives the wrap to address 0.
        addr <= addr + ADDR_W'(1);
        rem  <= rem - (ADDR_W+1)'(1);
      end
    end
  end

  always_comb begin
    state_next      = state;
    busy            = 1'b1;
    done            = 1'b0;
    rom_read_enable = 1'b0;
    rom_chip_enable = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (burst_len == '0) ? FIN : READ;
        end
      end
      READ: begin
        rom_read_enable = 1'b1;
        rom_chip_enable = 1'b1;
        if (can_load && rem_is_one) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_rom_burst_reader : randomized bench with a queue-based burst model
// Rev 1.0
// ---------------------------------------------------------------
module tb_rom_burst_reader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   burst_len;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_address;
  logic          rom_read_enable;
  logic          rom_chip_enable;
  logic [DW-1:0] rom_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  logic [DW-1:0] rom_mem [DEPTH];
  assign rom_data = rom_mem[rom_address];

  always #5 clk = ~clk;

  rom_burst_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .start_addr     (start_addr),
    .burst_len      (burst_len),
    .busy           (busy),
    .done           (done),
    .rom_address    (rom_address),
    .rom_read_enable(rom_read_enable),
    .rom_chip_enable(rom_chip_enable),
    .rom_data       (rom_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .out_ready      (out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Expected burst, straight from the address/length rules.
  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];
  logic [AW-1:0] exp_addr [$];

  // Observed burst.
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  logic [AW-1:0] got_addr [$];
  int  done_cnt, done_at, busy_cnt, valid_cnt, stall_viol;
  bit  timed_out;

  logic [5:0] pat = 6'b101001;

  task automatic build_model(input int a, input int n);
    exp_data.delete(); exp_last.delete(); exp_addr.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(AW'((a + i) % DEPTH));
      exp_data.push_back(rom_mem[(a + i) % DEPTH]);
      exp_last.push_back(i == n - 1);
    end
  endtask

  // Observation index k means "after edge E(k)", where E0 samples start.
  task automatic run_burst(input logic [AW-1:0] a, input logic [AW:0] n,
                           input int mode, input int restart_at);
    bit            prev_stall;
    bit            prev_read_stall;
    bit            finished;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] prev_addr;
    got_data.delete(); got_last.delete(); got_addr.delete();
    done_cnt = 0; done_at = -1; busy_cnt = 0; valid_cnt = 0; stall_viol = 0;
    prev_stall = 0; prev_read_stall = 0; finished = 0;
    prev_data = '0; prev_last = 0; prev_addr = '0;
    @(negedge clk);
    start = 1'b1; start_addr = a; burst_len = n; out_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (k == restart_at) begin
        start_addr = a + 4'd3;
        burst_len  = 5'd2;
      end
      if (!busy) begin
        finished = 1;
        break;
      end
      busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (out_valid) valid_cnt++;
      if (prev_stall && (out_data !== prev_data || out_last !== prev_last)) stall_viol++;
      if (prev_read_stall && rom_address !== prev_addr) stall_viol++;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[k % 6];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (rom_read_enable && (!out_valid || out_ready)) got_addr.push_back(rom_address);
      prev_stall      = out_valid && !out_ready;
      prev_data       = out_data;
      prev_last       = out_last;
      prev_read_stall = rom_read_enable && out_valid && !out_ready;
      prev_addr       = rom_address;
    end
    start = 1'b0;
    out_ready = 1'b1;
    timed_out = !finished;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    start_addr = '0; burst_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, out_valid, out_last, rom_read_enable, rom_chip_enable} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, out_valid, out_last, rom_read_enable, rom_chip_enable});
    end
    checks++;
    if (rom_address !== 4'd0 || out_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_regs: addr %0h data %0h expected 0 0", rom_address, out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    build_model(0, 4);
    run_burst(4'd0, 5'd4, 0, -1);
    checks++;
    if (timed_out || got_data.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d beats timeout %0b expected 4", got_data.size(), timed_out);
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL basic_beat%0d: data %0h last %0b expected %0h %0b",
                 i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
    checks++;
    if (valid_cnt != 4 || done_cnt != 1 || done_at != 5 || busy_cnt != 6) begin
      errors++;
      $display("FAIL basic_timing: valid %0d done %0d at %0d busy %0d expected 4 1 5 6",
               valid_cnt, done_cnt, done_at, busy_cnt);
    end
  endtask

  task automatic test_wrap();
    build_model(14, 4);
    run_burst(4'd14, 5'd4, 0, -1);
    checks++;
    if (timed_out || got_addr.size() != 4 || got_data.size() != 4) begin
      errors++;
      $display("FAIL wrap_count: addrs %0d beats %0d expected 4 4", got_addr.size(), got_data.size());
    end
    for (int i = 0; i < got_addr.size() && i < exp_addr.size() && i < got_data.size(); i++) begin
      checks++;
      if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL wrap_beat%0d: addr %0d data %0h expected %0d %0h",
                 i, got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
      end
    end
    checks++;
    if (done_at != 5) begin
      errors++;
      $display("FAIL wrap_done: done at %0d expected 5", done_at);
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, DEPTH - 1));
    build_model(int'(a), 3);
    run_burst(a, 5'd3, 1, -1);
    checks++;
    if (timed_out || got_data.size() != 3 || got_addr.size() != 3) begin
      errors++;
      $display("FAIL bp_count: beats %0d addrs %0d expected 3 3", got_data.size(), got_addr.size());
    end
    for (int i = 0; i < got_data.size() && i < 3 && i < got_addr.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_addr[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL bp_beat%0d: data %0h last %0b addr %0d expected %0h %0b %0d",
                 i, got_data[i], got_last[i], got_addr[i], exp_data[i], exp_last[i], exp_addr[i]);
      end
    end
    checks++;
    if (stall_viol != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_stall: violations %0d done %0d expected 0 1", stall_viol, done_cnt);
    end
  endtask

  task automatic test_zero_and_ignore();
    run_burst(4'd7, 5'd0, 0, -1);
    checks++;
    if (timed_out || done_cnt != 1 || done_at != 0 || valid_cnt != 0 || busy_cnt != 1
        || got_addr.size() != 0) begin
      errors++;
      $display("FAIL zero_len: done %0d at %0d valid %0d busy %0d reads %0d expected 1 0 0 1 0",
               done_cnt, done_at, valid_cnt, busy_cnt, got_addr.size());
    end
    build_model(3, 5);
    run_burst(4'd3, 5'd5, 0, 2);
    checks++;
    if (timed_out || got_data.size() != 5 || done_cnt != 1 || busy_cnt != 7) begin
      errors++;
      $display("FAIL ignore_start: beats %0d done %0d busy %0d expected 5 1 7",
               got_data.size(), done_cnt, busy_cnt);
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
        errors++;
        $display("FAIL ignore_beat%0d: data %0h last %0b expected %0h %0b",
                 i, got_data[i], got_last[i], exp_data[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_full_depth();
    build_model(5, 16);
    run_burst(4'd5, 5'd16, 0, -1);
    checks++;
    if (timed_out || got_data.size() != 16 || got_addr.size() != 16 || done_at != 17) begin
      errors++;
      $display("FAIL full_count: beats %0d addrs %0d done at %0d expected 16 16 17",
               got_data.size(), got_addr.size(), done_at);
    end
    for (int i = 0; i < got_data.size() && i < 16 && i < got_addr.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_addr[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL full_beat%0d: data %0h last %0b addr %0d expected %0h %0b %0d",
                 i, got_data[i], got_last[i], got_addr[i], exp_data[i], exp_last[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int beats;
    int dones;
    beats = 0; dones = 0;
    @(negedge clk);
    start = 1'b1; start_addr = 4'd9; burst_len = 5'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) dones++;
      if (out_valid && out_ready) beats++;
    end
    rst_n = 1'b0;
    checks++;
    if (beats != 2) begin
      errors++;
      $display("FAIL rstmid_beats: got %0d expected 2", beats);
    end
    @(negedge clk);
    checks++;
    if ({busy, out_valid, done, rom_read_enable, rom_chip_enable} !== 5'b0 || dones != 0) begin
      errors++;
      $display("FAIL rstmid_flags: got %b dones %0d expected 00000 0",
               {busy, out_valid, done, rom_read_enable, rom_chip_enable}, dones);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nodone: done %0b busy %0b expected 0 0", done, busy);
    end
    build_model(11, 5);
    run_burst(4'd11, 5'd5, 0, -1);
    checks++;
    if (timed_out || got_data.size() != 5 || done_cnt != 1) begin
      errors++;
      $display("FAIL rstmid_rerun: beats %0d done %0d expected 5 1", got_data.size(), done_cnt);
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i]) begin
        errors++;
        $display("FAIL rstmid_beat%0d: data %0h addr %0d expected %0h %0d",
                 i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [AW:0]   n;
    for (int t = 0; t < 8; t++) begin
      a = AW'($urandom_range(0, DEPTH - 1));
      n = (AW+1)'($urandom_range(1, DEPTH));
      build_model(int'(a), int'(n));
      run_burst(a, n, 2, -1);
      checks++;
      if (timed_out || got_data.size() != int'(n) || done_cnt != 1 || stall_viol != 0) begin
        errors++;
        $display("FAIL rand%0d_summary: beats %0d done %0d stalls %0d expected %0d 1 0",
                 t, got_data.size(), done_cnt, stall_viol, n);
      end
      for (int i = 0; i < got_data.size() && i < exp_data.size() && i < got_addr.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_addr[i] !== exp_addr[i]) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: data %0h last %0b addr %0d expected %0h %0b %0d",
                   t, i, got_data[i], got_last[i], got_addr[i], exp_data[i], exp_last[i], exp_addr[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_ignore();
    test_full_depth();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
- Sequencer that sits directly upstream of the ROM block.
- Drives the ROM's address, read_enable and chip_enable pins, and captures the ROM's asynchronous data_out.
- Presents the captured words as a valid/ready stream with a last marker.
- Turns a single start request (start address plus length) into a burst of consecutive ROM reads, with address wrap-around.

Parameters:
- ADDR_W, 4, ROM address width; the ROM depth is 2**ADDR_W.
- DATA_W, 8, ROM word width.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request pulse; accepted only in IDLE.
- start_addr  input  ADDR_W  first ROM address of the burst.
- burst_len  input  ADDR_W+1  number of words, 0..2**ADDR_W; 0 is a no-op.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a burst completes.
- rom_address  output  ADDR_W  drives ROM address.
- rom_read_enable  output  1  drives ROM read_enable.
- rom_chip_enable  output  1  drives ROM chip_enable.
- rom_data  input  DATA_W  ROM data_out; combinational w.r.t. rom_address.
- out_data  output  DATA_W  captured word.
- out_valid  output  1  out_data is valid.
- out_last  output  1  qualifies the final word of the burst.
- out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Behaviour:
- Reset: when rst_n is low at a clk edge:
  - state goes to IDLE.
  - busy, done, out_valid, out_last, rom_read_enable and rom_chip_enable go to 0.
  - rom_address and out_data go to 0; the remaining count goes to 0.
  - Reset mid-burst abandons the burst with no done pulse.
- States:
  - IDLE: waiting for start.
  - READ: issuing reads.
  - DRAIN: last word held, waiting for acceptance.
  - FIN: done pulse.
- IDLE:
  - Enables are low.
  - start=1 with burst_len>0: latch addr<=start_addr and rem<=burst_len; go to READ.
  - start=1 with burst_len=0: go to FIN (done pulse, no beats).
- READ:
  - rom_chip_enable=1 and rom_read_enable=1 (combinational from state).
  - rom_address = the addr register.
  - Define load = !out_valid || out_ready.
  - On load:
    - out_data<=rom_data, out_valid<=1, out_last<=(rem==1).
    - addr<=addr+1 modulo 2**ADDR_W; wrap 2**ADDR_W-1 -> 0.
    - rem<=rem-1.
  - If load and rem==1: go to DRAIN.
  - Without load: hold addr, rem and the output register (backpressure); enables stay asserted.
- DRAIN:
  - Enables are low.
  - When out_valid && out_ready: out_valid<=0 and out_last<=0; go to FIN.
- FIN: done=1 for exactly one cycle; next state IDLE.
- busy = (state != IDLE); busy is low during the cycle after FIN.
- start while busy: ignored, not queued.
- Latency: start sampled at edge E0 -> first word has out_valid=1 after edge E1.
- Throughput: with out_ready held at 1, one word per cycle.
  - For burst length N, the last word is valid after edge E(N).
  - done is high after edge E(N+1), with the last word accepted at that edge.
- out_data and out_last must hold stable while out_valid && !out_ready.
- Full 2**ADDR_W burst:
  - rem is wide enough to hold 16 without overflow.
  - The address wraps back to start_addr.
- No combinational path from out_ready to rom_address: rom_address is the addr register only.

Decomposition:
- Shared package (rom_pkg):
  - ROM_ADDR_W=4 and ROM_DATA_W=8 constants.
  - State enum: IDLE, READ, DRAIN, FIN (2-bit encoding).
- One natural sub-module: rom_stream_reg, the DATA_W+1-wide valid/ready holding register (load/hold logic).
- The FSM, address counter and remaining counter stay in the top level.

Test Plan:
- Basic burst with the real ROM model attached:
  - Stimulus: rst_n=0 for 2 cycles, then start=1, start_addr=0, burst_len=4, out_ready=1.
  - Response: four beats on consecutive cycles equal to ROM[0..3].
  - out_last only on the 4th beat; done pulses one cycle after the 4th beat; busy is high for 6 cycles.
- Wrap-around:
  - Stimulus: start_addr=14, burst_len=4.
  - Response: rom_address sequence 14, 15, 0, 1; data equals ROM[14], ROM[15], ROM[0], ROM[1].
- Backpressure:
  - Stimulus: burst_len=3, out_ready toggling 1,0,0,1,0,1,...
  - Response: no word lost or duplicated; out_data is stable while stalled; rom_address holds during stalls; 3 accepted beats.
- Zero length and ignored start:
  - Stimulus: burst_len=0.
  - Response: done pulse 1 cycle after start, with no out_valid.
  - Stimulus: start reasserted mid-burst.
  - Response: the burst is unaffected; no second burst follows.
- Full depth:
  - Stimulus: start_addr=5, burst_len=16.
  - Response: 16 beats covering every address exactly once, ending at address 4; out_last on beat 16.
- Reset mid-burst:
  - Stimulus: rst_n=0 after 2 beats of an 8-word burst.
  - Response: after the next edge, busy, out_valid, done and both enables are 0, with no done pulse.
  - A new burst afterwards runs correctly from its own start_addr.
